// File: rtl/bmf_basis_decoder.sv
// Streaming basis-matrix decoder: rebuilds an M-bit approximate output from a K-bit
// latent code using a runtime-loaded basis, with optional error statistics.
module bmf_basis_decoder #(
   parameter int K     = 3,
   parameter int M     = 6,
   parameter int CNT_W = 16,
   localparam int RW   = (K > 1) ? $clog2(K) : 1,
   localparam int PW   = $clog2(M + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_we,
   input  logic [RW-1:0]    cfg_row,
   input  logic [M-1:0]     cfg_data,
   input  logic             cfg_commit,
   input  logic             cfg_xor,
   output logic             cfg_err,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [K-1:0]     s_code,
   input  logic [M-1:0]     s_ref,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [M-1:0]     m_out,
   output logic [M-1:0]     m_err,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_samples,
   output logic [CNT_W-1:0] stat_err_samples,
   output logic [CNT_W-1:0] stat_err_bits
);

   typedef enum logic {LOAD, RUN} state_t;

   state_t          state;
   logic            xor_mode;
   logic [M-1:0]    basis [K];
   logic [M-1:0]    dec;
   logic [PW-1:0]   pop;
   logic [CNT_W:0]  bits_sum;
   logic            row_bad;
   logic            accept;
   logic            handoff;

   assign row_bad = ({1'b0, cfg_row} >= (RW + 1)'(K));
   assign s_ready = (state == RUN) && (!m_valid || m_ready);
   assign accept  = s_valid && s_ready;
   assign handoff = m_valid && m_ready;

   // Configuration FSM: basis is writable only in LOAD; any config access in RUN is flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LOAD;
         xor_mode <= 1'b0;
         cfg_err  <= 1'b0;
         for (int i = 0; i < K; i++) basis[i] <= '0;
      end else begin
         case (state)
            LOAD: begin
               if (cfg_we) begin
                  if (row_bad) cfg_err <= 1'b1;
                  for (int i = 0; i < K; i++)
                     if (!row_bad && cfg_row == RW'(i)) basis[i] <= cfg_data;
               end
               if (cfg_commit) begin
                  xor_mode <= cfg_xor;
                  state    <= RUN;
               end
            end
            RUN: begin
               if (cfg_we || cfg_commit) cfg_err <= 1'b1;
            end
            default: state <= LOAD;
         endcase
      end
   end

   always_comb begin
      dec = '0;
      for (int i = 0; i < K; i++)
         if (s_code[i]) dec = xor_mode ? (dec ^ basis[i]) : (dec | basis[i]);
   end

   // Single output register; holds while stalled and refills in the same cycle as a handoff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_out   <= '0;
         m_err   <= '0;
      end else if (accept) begin
         m_valid <= 1'b1;
         m_out   <= dec;
         m_err   <= dec ^ s_ref;
      end else if (handoff) begin
         m_valid <= 1'b0;
      end
   end

   always_comb begin
      pop = '0;
      for (int j = 0; j < M; j++) pop = pop + PW'(m_err[j]);
   end

   assign bits_sum = {1'b0, stat_err_bits} + (CNT_W + 1)'(pop);

   // Saturating statistics; a clear wins over a coincident handoff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_samples     <= '0;
         stat_err_samples <= '0;
         stat_err_bits    <= '0;
      end else if (stat_clr) begin
         stat_samples     <= '0;
         stat_err_samples <= '0;
         stat_err_bits    <= '0;
      end else if (handoff) begin
         if (stat_samples != '1) stat_samples <= stat_samples + 1'b1;
         if (m_err != '0 && stat_err_samples != '1)
            stat_err_samples <= stat_err_samples + 1'b1;
         stat_err_bits <= bits_sum[CNT_W] ? '1 : bits_sum[CNT_W-1:0];
      end
   end

endmodule

// File: tb/tb_bmf_basis_decoder.sv
// Directed bench for bmf_basis_decoder: OR/XOR decode tables plus hand-written
// sequences for config errors, back-pressure, counter saturation and reset.
module tb_bmf_basis_decoder;

   localparam int K = 3;
   localparam int M = 6;
   localparam int CNT_W = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cfg_we = 1'b0;
   logic [1:0]   cfg_row = '0;
   logic [M-1:0] cfg_data = '0;
   logic         cfg_commit = 1'b0;
   logic         cfg_xor = 1'b0;
   logic         cfg_err;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [K-1:0] s_code = '0;
   logic [M-1:0] s_ref = '0;
   logic         m_valid;
   logic         m_ready = 1'b1;
   logic [M-1:0] m_out;
   logic [M-1:0] m_err;
   logic         stat_clr = 1'b0;
   logic [CNT_W-1:0] stat_samples;
   logic [CNT_W-1:0] stat_err_samples;
   logic [CNT_W-1:0] stat_err_bits;

   int checks = 0;
   int failures = 0;
   logic mon_en = 1'b0;
   logic [M-1:0] seen [$];

   typedef struct {
      logic [K-1:0] code;
      logic [M-1:0] ref_w;
      logic [M-1:0] exp_out;
      logic [M-1:0] exp_err;
   } vec_t;

   vec_t vecs [9];

   bmf_basis_decoder #(.K(K), .M(M), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_row(cfg_row), .cfg_data(cfg_data),
      .cfg_commit(cfg_commit), .cfg_xor(cfg_xor), .cfg_err(cfg_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_code(s_code), .s_ref(s_ref),
      .m_valid(m_valid), .m_ready(m_ready), .m_out(m_out), .m_err(m_err),
      .stat_clr(stat_clr), .stat_samples(stat_samples),
      .stat_err_samples(stat_err_samples), .stat_err_bits(stat_err_bits)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (mon_en && m_valid && m_ready) seen.push_back(m_out);

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic loadRow(input logic [1:0] row, input logic [M-1:0] data);
      cfg_we = 1'b1; cfg_row = row; cfg_data = data;
      @(posedge clk); #1;
      cfg_we = 1'b0;
   endtask

   task automatic applyStimulus(input logic [K-1:0] c, input logic [M-1:0] r);
      int n = 0;
      s_valid = 1'b1; s_code = c; s_ref = r;
      @(negedge clk);
      while (!s_ready && n < 20) begin n++; @(negedge clk); end
      checkOutput("send_ready", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic checkStats(input string name, input int smp, input int es, input int eb);
      checkOutput({name, "_samples"}, 32'(stat_samples), smp);
      checkOutput({name, "_err_samples"}, 32'(stat_err_samples), es);
      checkOutput({name, "_err_bits"}, 32'(stat_err_bits), eb);
   endtask

   task automatic runVectors(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         applyStimulus(vecs[i].code, vecs[i].ref_w);
         s_valid = 1'b0;
         checkOutput($sformatf("vec%0d_valid", i), 32'(m_valid), 32'd1);
         checkOutput($sformatf("vec%0d_out", i), 32'(m_out), 32'(vecs[i].exp_out));
         checkOutput($sformatf("vec%0d_err", i), 32'(m_err), 32'(vecs[i].exp_err));
      end
      @(posedge clk); #1;
   endtask

   initial begin
      // OR basis rows 0=001001, 1=010000, 2=100000
      vecs[0] = '{3'b101, 6'b101001, 6'b101001, 6'b000000};
      vecs[1] = '{3'b111, 6'b111111, 6'b111001, 6'b000110};
      vecs[2] = '{3'b000, 6'b000011, 6'b000000, 6'b000011};
      vecs[3] = '{3'b010, 6'b010000, 6'b010000, 6'b000000};
      vecs[4] = '{3'b110, 6'b000000, 6'b110000, 6'b110000};
      // XOR basis rows 0=000011, 1=000110, 2=100000
      vecs[5] = '{3'b011, 6'b000101, 6'b000101, 6'b000000};
      vecs[6] = '{3'b111, 6'b000000, 6'b100101, 6'b100101};
      vecs[7] = '{3'b101, 6'b100011, 6'b100011, 6'b000000};
      vecs[8] = '{3'b110, 6'b100110, 6'b100110, 6'b000000};

      #12;
      checkOutput("rst_m_valid", 32'(m_valid), 0);
      checkOutput("rst_m_out", 32'(m_out), 0);
      checkOutput("rst_m_err", 32'(m_err), 0);
      checkOutput("rst_s_ready", 32'(s_ready), 0);
      checkOutput("rst_cfg_err", 32'(cfg_err), 0);
      checkStats("rst", 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      loadRow(2'd0, 6'b001001);
      loadRow(2'd1, 6'b010000);
      loadRow(2'd2, 6'b100000);
      checkOutput("load_s_ready", 32'(s_ready), 0);
      cfg_commit = 1'b1; cfg_xor = 1'b0;
      @(posedge clk); #1;
      cfg_commit = 1'b0;
      checkOutput("run_s_ready", 32'(s_ready), 1);
      runVectors(0, 4);
      checkStats("or", 5, 3, 6);

      // Config access in RUN must flag and leave the basis alone
      loadRow(2'd0, 6'b111111);
      checkOutput("run_cfg_err", 32'(cfg_err), 1);
      applyStimulus(3'b001, 6'b001001);
      s_valid = 1'b0;
      checkOutput("run_basis_kept", 32'(m_out), 32'(6'b001001));
      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;
      checkOutput("clr_handoff_valid", 32'(m_valid), 0);
      checkStats("clr", 0, 0, 0);

      // 20 back-to-back handoffs, each with two error bits
      s_valid = 1'b1; s_code = 3'b111; s_ref = 6'b111111;
      repeat (20) @(posedge clk);
      #1 s_valid = 1'b0;
      @(posedge clk); #1;
      checkStats("sat", 15, 15, 15);

      stat_clr = 1'b1;
      @(posedge clk); #1;
      stat_clr = 1'b0;

      // Back-pressure with three stalled cycles while code 2 is held
      mon_en = 1'b1;
      applyStimulus(3'd1, 6'b001001);
      applyStimulus(3'd2, 6'b010000);
      s_code = 3'd3; s_ref = 6'b011001; m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput($sformatf("stall%0d_s_ready", i), 32'(s_ready), 0);
         checkOutput($sformatf("stall%0d_m_out", i), 32'(m_out), 32'(6'b010000));
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      applyStimulus(3'd3, 6'b011001);
      applyStimulus(3'd4, 6'b100000);
      s_valid = 1'b0;
      @(posedge clk); #1;
      mon_en = 1'b0;
      checkOutput("bp_count", seen.size(), 4);
      if (seen.size() == 4) begin
         checkOutput("bp_out0", 32'(seen[0]), 32'(6'b001001));
         checkOutput("bp_out1", 32'(seen[1]), 32'(6'b010000));
         checkOutput("bp_out2", 32'(seen[2]), 32'(6'b011001));
         checkOutput("bp_out3", 32'(seen[3]), 32'(6'b100000));
      end
      checkStats("bp", 4, 0, 0);

      // Reset while an output is held
      m_ready = 1'b0;
      applyStimulus(3'b101, 6'b000000);
      s_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_m_valid", 32'(m_valid), 0);
      checkOutput("midrst_s_ready", 32'(s_ready), 0);
      checkOutput("midrst_cfg_err", 32'(cfg_err), 0);
      checkStats("midrst", 0, 0, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_ready = 1'b1;

      // XOR load with an out-of-range row, then write+commit in one cycle
      loadRow(2'd0, 6'b000011);
      loadRow(2'd1, 6'b000110);
      loadRow(2'd3, 6'b111111);
      checkOutput("bad_row_cfg_err", 32'(cfg_err), 1);
      checkOutput("bad_row_s_ready", 32'(s_ready), 0);
      cfg_we = 1'b1; cfg_row = 2'd2; cfg_data = 6'b100000;
      cfg_commit = 1'b1; cfg_xor = 1'b1;
      @(posedge clk); #1;
      cfg_we = 1'b0; cfg_commit = 1'b0; cfg_xor = 1'b0;
      checkOutput("xor_s_ready", 32'(s_ready), 1);
      runVectors(5, 8);
      checkStats("xor", 4, 1, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bmf_basis_decoder.md
Name: bmf_basis_decoder

Overview:
- Streaming decompressor for the BMF-partitioned approximate circuits.
- Accepts K-bit latent codes produced by a w-side compressor and rebuilds the M-bit approximate output using a runtime-loaded basis (H) matrix. Reconstruction is Boolean OR-of-rows or GF(2) XOR-of-rows.
- Optionally compares each output against a supplied exact reference word and accumulates error statistics for design-space evaluation.
- Sits after the latent-code generator in the evaluation harness and replaces hard-wired h-side logic.

Parameters:
- K, 3, latent code width (number of basis rows).
- M, 6, reconstructed output width.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  basis row write strobe.
- cfg_row  in  max(1,$clog2(K))  basis row index.
- cfg_data  in  M  basis row contents; bit j contributes to out[j].
- cfg_commit  in  1  leaves LOAD and enters RUN.
- cfg_xor  in  1  combine mode, sampled at commit: 0 = OR, 1 = XOR.
- cfg_err  out  1  sticky; set by an illegal config access.
- s_valid  in  1  input code valid.
- s_ready  out  1  input code accepted when s_valid && s_ready.
- s_code  in  K  latent code k[K-1:0].
- s_ref  in  M  exact reference output for this code.
- m_valid  out  1  output valid.
- m_ready  in  1  downstream ready.
- m_out  out  M  reconstructed output.
- m_err  out  M  m_out ^ reference, bitwise.
- stat_clr  in  1  synchronous clear of all counters.
- stat_samples  out  CNT_W  completed output handoffs.
- stat_err_samples  out  CNT_W  handoffs with m_err != 0.
- stat_err_bits  out  CNT_W  sum of popcount(m_err) over handoffs.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; basis rows=0; mode=OR.
  - m_valid=0, m_out=0, m_err=0, s_ready=0, cfg_err=0; all counters 0.
- FSM with two states, LOAD and RUN:
  - LOAD:
    - s_ready=0.
    - cfg_we writes basis[cfg_row] <= cfg_data. If cfg_row >= K, the write is dropped and cfg_err is set.
    - cfg_commit latches cfg_xor and moves to RUN next cycle.
    - cfg_we and cfg_commit in the same cycle: the write is applied, then commit, so the row written is visible in RUN.
  - RUN:
    - cfg_we and cfg_commit are ignored, and either one sets cfg_err.
    - The only way back to LOAD is reset. Basis is fixed for the run.
- Decode: m_out_next[j] = reduce_op over i in 0..K-1 of (s_code[i] & basis[i][j]), where reduce_op is OR or XOR per the latched mode. A code of 0 gives 0.
- Pipeline:
  - Single registered stage; latency 1 cycle from acceptance to m_valid.
  - s_ready = (state==RUN) && (!m_valid || m_ready). Full throughput of 1 code per cycle while m_ready=1.
  - On acceptance: m_out and m_err (m_out_next ^ s_ref) are registered and m_valid=1.
  - Output held stable while m_valid && !m_ready.
  - m_valid drops after a handoff only if no new acceptance happens in the same cycle.
- Statistics:
  - Updated on each output handoff (m_valid && m_ready).
  - samples += 1; err_samples += (m_err!=0); err_bits += popcount(m_err).
  - Every counter saturates at 2^CNT_W-1 and never wraps. err_bits saturates when the sum would overflow.
  - stat_clr has priority: a handoff in the same cycle is not counted and all counters become 0.
  - Counters keep running across back-pressure; stalled cycles add nothing.
- Reset mid-stream discards any held output with no handoff counted. The basis must be reloaded before the next run.

Test Plan:
- Reset, load rows 0=6'b001001, 1=6'b010000, 2=6'b100000, commit OR; send s_code=3'b101, s_ref=6'b101001 -> m_out=6'b101001, m_err=0 one cycle after acceptance; samples=1, err_samples=0, err_bits=0.
- Same basis; s_code=3'b111, s_ref=6'b111111 -> m_out=6'b111001, m_err=6'b000110; err_samples=1, err_bits=2.
- XOR mode, rows 0=6'b000011, 1=6'b000110; s_code=3'b011 -> m_out=6'b000101 (OR mode would give 6'b000111).
- Back-pressure: stream codes 1..4 with m_ready low for 3 cycles at code 2 -> s_ready=0 while stalled, m_out holds code-2 result, all 4 results delivered in order, samples=4.
- cfg_we in RUN, or cfg_row=3 in LOAD with K=3 -> cfg_err=1, basis unchanged; s_ready=0 until commit.
- CNT_W=4: 20 handoffs -> samples=15 (saturated); stat_clr asserted during a handoff -> all counters 0 next cycle; rst_n low mid-stall -> m_valid=0 immediately.
